chime_tone_gen: RTL and testbench

Parametrised chime and alarm tone generator for the BCD digital clock. It watches the clock's BCD time digits and drives the piezo buzzer line for three events: the hourly countdown pips at mm:50–mm:59, the top-of-hour tone at mm:00, and a user alarm. Each event has its own tone pitch, and mute and acknowledge are supported. It sits between the time counter chain and the buzzer pin, replacing the fixed two-tone buzzer block.

---
 rtl/chime_pkg.sv | 15 +
 rtl/chime_tone_gen_if.sv | 20 ++
 rtl/chime_tone_gen_divider.sv | 48 ++++
 rtl/chime_tone_gen.sv | 130 +++++++++++++
 tb/tb_chime_tone_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chime_pkg.sv
// Shared types and constants for the chime / alarm tone generator.
package chime_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PIP, ST_TOP, ST_ALARM} state_e;
   typedef enum logic [1:0] {TONE_SILENT, TONE_LOW, TONE_HIGH} tone_e;

   localparam logic [3:0] BCD_0 = 4'd0;
   localparam logic [3:0] BCD_5 = 4'd5;
   localparam logic [3:0] BCD_9 = 4'd9;

   function automatic logic bcd_ok(input logic [3:0] d);
      return d <= BCD_9;
   endfunction

endpackage

// File: rtl/chime_tone_gen_if.sv
// Time digits, alarm controls and buzzer outputs of the chime generator.
interface chime_tone_gen_if;
   logic [3:0]  SecL, SecH, MinL, MinH, HourL, HourH;
   logic        Alarm_En;
   logic [15:0] Alarm_HM;
   logic        Stop;
   logic        Mute;
   logic        Buzzer_Out;
   logic        Alarm_Active;

   modport master (
      output SecL, SecH, MinL, MinH, HourL, HourH, Alarm_En, Alarm_HM, Stop, Mute,
      input  Buzzer_Out, Alarm_Active
   );

   modport slave (
      input  SecL, SecH, MinL, MinH, HourL, HourH, Alarm_En, Alarm_HM, Stop, Mute,
      output Buzzer_Out, Alarm_Active
   );
endinterface

// File: rtl/chime_tone_gen_divider.sv
// Square-wave divider: half-period chosen by tone code, restarts on any code change.
module tone_divider
   import chime_pkg::*;
#(
   parameter int CNT_W   = 23,
   parameter int LO_HALF = 50_000,
   parameter int HI_HALF = 25_000
) (
   input  logic  CLK,
   input  logic  RSTn,
   input  tone_e tone_i,
   output logic  wave_o
);

   tone_e            tone_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, half_m1;
   logic             wave_q, wave_d;

   always_comb begin
      half_m1 = (tone_i == TONE_HIGH) ? CNT_W'(HI_HALF - 1) : CNT_W'(LO_HALF - 1);
      cnt_d   = cnt_q;
      wave_d  = wave_q;
      if ((tone_i != tone_q) || (tone_i == TONE_SILENT)) begin
         cnt_d  = '0;
         wave_d = 1'b1;
      end else if (cnt_q == half_m1) begin
         cnt_d  = '0;
         wave_d = ~wave_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         tone_q <= TONE_SILENT;
         cnt_q  <= '0;
         wave_q <= 1'b1;
      end else begin
         tone_q <= tone_i;
         cnt_q  <= cnt_d;
         wave_q <= wave_d;
      end
   end

   assign wave_o = wave_q;

endmodule

// File: rtl/chime_tone_gen.sv
// Chime and alarm tone generator: hourly pips, top-of-hour tone and warbling alarm.
module chime_tone_gen
   import chime_pkg::*;
#(
   parameter int CNT_W     = 23,
   parameter int LO_HALF   = 50_000,
   parameter int HI_HALF   = 25_000,
   parameter int PAT_CYC   = 12_500_000,
   parameter int ALARM_SEC = 60
) (
   input  logic           CLK,
   input  logic           RSTn,
   chime_tone_gen_if.slave bus
);

   logic [3:0]       sec_l_q;
   logic             tick, time_ok;
   logic             hm_match_q, sec_zero_q, top_q, pip_q;
   state_e           state_q, state_d;
   logic [7:0]       sec_cnt_q, sec_cnt_d;
   logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
   logic             phase_q, phase_d;
   logic             ack_q, ack_d;
   logic             auto_stop, stay, enter;
   tone_e            tone_d;
   logic             wave;

   assign tick    = (bus.SecL != sec_l_q);
   assign time_ok = bcd_ok(bus.SecL) && bcd_ok(bus.SecH) && bcd_ok(bus.MinL) &&
                    bcd_ok(bus.MinH) && bcd_ok(bus.HourL) && bcd_ok(bus.HourH);

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sec_l_q    <= '0;
         hm_match_q <= 1'b0;
         sec_zero_q <= 1'b0;
         top_q      <= 1'b0;
         pip_q      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         sec_l_q    <= bus.SecL;
         hm_match_q <= time_ok && bus.Alarm_En &&
                       ({bus.HourH, bus.HourL, bus.MinH, bus.MinL} == bus.Alarm_HM);
         sec_zero_q <= time_ok && (bus.SecH == BCD_0) && (bus.SecL == BCD_0);
         top_q      <= time_ok && (bus.MinH == BCD_0) && (bus.MinL == BCD_0) &&
                       (bus.SecH == BCD_0) && (bus.SecL == BCD_0);
         pip_q      <= time_ok && (bus.MinH == BCD_5) && (bus.MinL == BCD_9) &&
                       (bus.SecH == BCD_5);
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d   = ST_IDLE;
      sec_cnt_d = sec_cnt_q;
      pat_cnt_d = '0;
      phase_d   = 1'b0;
      ack_d     = ack_q;
      auto_stop = 1'b0;
      stay      = 1'b0;
      tone_d    = TONE_SILENT;

      if (state_q == ST_ALARM) begin
         if (tick) sec_cnt_d = sec_cnt_q + 8'd1;
         auto_stop = tick && (sec_cnt_d == 8'(ALARM_SEC));
         stay      = !bus.Stop && bus.Alarm_En && !auto_stop;
      end
      enter = (state_q != ST_ALARM) && hm_match_q && sec_zero_q && !ack_q && !bus.Stop;

      if (stay) begin
         state_d = ST_ALARM;
         if (pat_cnt_q == CNT_W'(PAT_CYC - 1)) begin
            phase_d = ~phase_q;
         end else begin
            pat_cnt_d = pat_cnt_q + CNT_W'(1);
            phase_d   = phase_q;
         end
      end else if (enter) begin
         state_d   = ST_ALARM;
         sec_cnt_d = '0;
      end else if (top_q) begin
         state_d = ST_TOP;
      end else if (pip_q) begin
         state_d = ST_PIP;
      end

      // The acknowledge only lives as long as the alarm minute keeps matching.
      if (!hm_match_q)                 ack_d = 1'b0;
      else if (bus.Stop || auto_stop)  ack_d = 1'b1;

      // Tone follows the next state so the divider restarts on the same edge as the state.
      unique case (state_d)
         ST_IDLE:  tone_d = TONE_SILENT;
         ST_PIP:   tone_d = sec_l_q[0] ? TONE_SILENT : TONE_LOW;
         ST_TOP:   tone_d = TONE_HIGH;
         ST_ALARM: tone_d = phase_d ? TONE_LOW : TONE_HIGH;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= ST_IDLE;
         sec_cnt_q <= '0;
         pat_cnt_q <= '0;
         phase_q   <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_cnt_q <= sec_cnt_d;
         pat_cnt_q <= pat_cnt_d;
         phase_q   <= phase_d;
         ack_q     <= ack_d;
      end
   end

   tone_divider #(
      .CNT_W   (CNT_W),
      .LO_HALF (LO_HALF),
      .HI_HALF (HI_HALF)
   ) u_div (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .tone_i (tone_d),
      .wave_o (wave)
   );

   assign bus.Buzzer_Out   = bus.Mute | wave;
   assign bus.Alarm_Active = (state_q == ST_ALARM);

endmodule

// File: tb/tb_chime_tone_gen.sv
// Directed bench for chime_tone_gen with short tone and warble periods.
module tb_chime_tone_gen;

   logic CLK = 1'b0;
   logic RSTn;
   int   n_cmp = 0;
   int   n_bad = 0;

   chime_tone_gen_if bus ();

   chime_tone_gen #(
      .CNT_W     (8),
      .LO_HALF   (4),
      .HI_HALF   (2),
      .PAT_CYC   (16),
      .ALARM_SEC (3)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Expected level o clocks after the divider restarts on a given tone.
   function automatic logic hi_lvl(input int o);
      return ((o / 2) % 2) == 0;
   endfunction

   function automatic logic lo_lvl(input int o);
      return ((o / 4) % 2) == 0;
   endfunction

   task automatic set_time(input logic [23:0] t);
      {bus.HourH, bus.HourL, bus.MinH, bus.MinL, bus.SecH, bus.SecL} = t;
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      set_time(24'h123456);
      bus.Alarm_En = 1'b0;
      bus.Alarm_HM = 16'h0000;
      bus.Stop     = 1'b0;
      bus.Mute     = 1'b0;
      RSTn         = 1'b1;
      #23 RSTn = 1'b0;
      #1;
      n_cmp++;
      if (bus.Buzzer_Out !== 1'b1) begin
         n_bad++; $display("FAIL reset_buzzer got %b want 1", bus.Buzzer_Out);
      end
      n_cmp++;
      if (bus.Alarm_Active !== 1'b0) begin
         n_bad++; $display("FAIL reset_active got %b want 0", bus.Alarm_Active);
      end
      repeat (3) step();
      RSTn = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         n_cmp++;
         if (bus.Buzzer_Out !== 1'b1 || bus.Alarm_Active !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset k=%0d got buz=%b act=%b want buz=1 act=0",
                     k, bus.Buzzer_Out, bus.Alarm_Active);
         end
      end
   endtask

   task automatic test_pips();
      set_time(24'h125949);
      repeat (3) step();
      set_time(24'h125950);
      for (int k = 0; k <= 20; k++) begin
         logic exp;
         step();
         exp = (k == 0) ? 1'b1 : lo_lvl(k - 1);
         n_cmp++;
         if (bus.Buzzer_Out !== exp) begin
            n_bad++; $display("FAIL pip50 k=%0d got %b want %b", k, bus.Buzzer_Out, exp);
         end
      end
      set_time(24'h125951);
      step();
      for (int k = 1; k <= 8; k++) begin
         step();
         n_cmp++;
         if (bus.Buzzer_Out !== 1'b1) begin
            n_bad++; $display("FAIL pip51 k=%0d got %b want 1", k, bus.Buzzer_Out);
         end
      end
   endtask

   task automatic test_top();
      set_time(24'h110000);
      for (int k = 0; k <= 12; k++) begin
         logic exp;
         step();
         exp = (k == 0) ? 1'b1 : hi_lvl(k - 1);
         n_cmp++;
         if (bus.Buzzer_Out !== exp) begin
            n_bad++; $display("FAIL top k=%0d got %b want %b", k, bus.Buzzer_Out, exp);
         end
      end
      set_time(24'h110001);
      step();
      for (int k = 1; k <= 8; k++) begin
         step();
         n_cmp++;
         if (bus.Buzzer_Out !== 1'b1) begin
            n_bad++; $display("FAIL top_end k=%0d got %b want 1", k, bus.Buzzer_Out);
         end
      end
   endtask

   task automatic test_reset_mid_tone();
      set_time(24'h110000);
      repeat (4) step();
      n_cmp++;
      if (bus.Buzzer_Out !== 1'b0) begin
         n_bad++; $display("FAIL midtone_low got %b want 0", bus.Buzzer_Out);
      end
      #2 RSTn = 1'b0;
      #1;
      n_cmp++;
      if (bus.Buzzer_Out !== 1'b1 || bus.Alarm_Active !== 1'b0) begin
         n_bad++;
         $display("FAIL midtone_reset got buz=%b act=%b want buz=1 act=0",
                  bus.Buzzer_Out, bus.Alarm_Active);
      end
      set_time(24'h123456);
      repeat (2) step();
      RSTn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         n_cmp++;
         if (bus.Buzzer_Out !== 1'b1) begin
            n_bad++; $display("FAIL midtone_release k=%0d got %b want 1", k, bus.Buzzer_Out);
         end
      end
   endtask

   task automatic test_alarm_warble();
      bus.Alarm_HM = 16'h0730;
      bus.Alarm_En = 1'b1;
      set_time(24'h072959);
      repeat (3) step();
      set_time(24'h073000);
      step();
      n_cmp++;
      if (bus.Alarm_Active !== 1'b0) begin
         n_bad++; $display("FAIL alarm_latency got %b want 0", bus.Alarm_Active);
      end
      for (int k = 1; k <= 41; k++) begin
         int   j;
         logic exp;
         step();
         j   = k - 1;
         exp = (j < 16) ? hi_lvl(j) : (j < 32) ? lo_lvl(j - 16) : hi_lvl(j - 32);
         n_cmp++;
         if (bus.Alarm_Active !== 1'b1 || bus.Buzzer_Out !== exp) begin
            n_bad++;
            $display("FAIL warble k=%0d got buz=%b act=%b want buz=%b act=1",
                     k, bus.Buzzer_Out, bus.Alarm_Active, exp);
         end
      end
      set_time(24'h073001);
      repeat (3) step();
      n_cmp++;
      if (bus.Alarm_Active !== 1'b1) begin
         n_bad++; $display("FAIL alarm_sec1 got %b want 1", bus.Alarm_Active);
      end
      set_time(24'h073002);
      repeat (3) step();
      n_cmp++;
      if (bus.Alarm_Active !== 1'b1) begin
         n_bad++; $display("FAIL alarm_sec2 got %b want 1", bus.Alarm_Active);
      end
      set_time(24'h073003);
      repeat (2) step();
      n_cmp++;
      if (bus.Alarm_Active !== 1'b0) begin
         n_bad++; $display("FAIL auto_stop got %b want 0", bus.Alarm_Active);
      end
      step();
      n_cmp++;
      if (bus.Buzzer_Out !== 1'b1) begin
         n_bad++; $display("FAIL auto_stop_quiet got %b want 1", bus.Buzzer_Out);
      end
      set_time(24'h073000);
      for (int k = 1; k <= 6; k++) begin
         step();
         n_cmp++;
         if (bus.Alarm_Active !== 1'b0) begin
            n_bad++; $display("FAIL no_retrigger k=%0d got %b want 0", k, bus.Alarm_Active);
         end
      end
   endtask

   task automatic test_alarm_hour();
      bus.Alarm_HM = 16'h0800;
      set_time(24'h075859);
      repeat (3) step();
      set_time(24'h080000);
      step();
      for (int k = 1; k <= 20; k++) begin
         int   j;
         logic exp;
         step();
         j   = k - 1;
         exp = (k >= 6 && k <= 13) ? 1'b1 : (j < 16) ? hi_lvl(j) : lo_lvl(j - 16);
         n_cmp++;
         if (bus.Alarm_Active !== 1'b1 || bus.Buzzer_Out !== exp) begin
            n_bad++;
            $display("FAIL alarm_hour k=%0d got buz=%b act=%b want buz=%b act=1",
                     k, bus.Buzzer_Out, bus.Alarm_Active, exp);
         end
         if (k == 5)  bus.Mute = 1'b1;
         if (k == 13) bus.Mute = 1'b0;
      end
      bus.Stop = 1'b1;
      step();
      bus.Stop = 1'b0;
      n_cmp++;
      if (bus.Alarm_Active !== 1'b0) begin
         n_bad++; $display("FAIL stop_active got %b want 0", bus.Alarm_Active);
      end
      for (int k = 21; k <= 30; k++) begin
         logic exp;
         if (k > 21) step();
         exp = hi_lvl(k - 21);
         n_cmp++;
         if (bus.Buzzer_Out !== exp) begin
            n_bad++; $display("FAIL stop_top k=%0d got %b want %b", k, bus.Buzzer_Out, exp);
         end
      end
   endtask

   task automatic test_stop_with_entry();
      bus.Alarm_HM = 16'h0900;
      set_time(24'h085959);
      repeat (3) step();
      set_time(24'h090000);
      step();
      bus.Stop = 1'b1;
      step();
      bus.Stop = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         logic exp;
         if (k > 1) step();
         exp = hi_lvl(k - 1);
         n_cmp++;
         if (bus.Alarm_Active !== 1'b0 || bus.Buzzer_Out !== exp) begin
            n_bad++;
            $display("FAIL stop_entry k=%0d got buz=%b act=%b want buz=%b act=0",
                     k, bus.Buzzer_Out, bus.Alarm_Active, exp);
         end
      end
   endtask

   task automatic test_invalid_bcd();
      bus.Alarm_En = 1'b0;
      set_time(24'h105948);
      repeat (3) step();
      set_time(24'h10595A);
      for (int k = 0; k <= 12; k++) begin
         step();
         n_cmp++;
         if (bus.Buzzer_Out !== 1'b1 || bus.Alarm_Active !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_bcd k=%0d got buz=%b act=%b want buz=1 act=0",
                     k, bus.Buzzer_Out, bus.Alarm_Active);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pips();
      test_top();
      test_reset_mid_tone();
      test_alarm_warble();
      test_alarm_hour();
      test_stop_with_entry();
      test_invalid_bcd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
